// File: rtl/traffic_lamp_driver.sv
// traffic_lamp_driver
// Registered lamp stage behind the traffic-light controller. It mirrors the
// controller's lamp requests in RUN, flashes yellow while idle, and latches a
// fault that flashes red until fault_clr. A fault comes from an illegal request
// pattern, or from a request vector that stays unchanged for too long.
// Optional feature macro: LAMP_PWM_EN. When it is defined, lamps are dimmed by
// duty. When it is undefined, lamps are fully on and duty is ignored.
//
// mode   | meaning
// IDLE   | disabled or controller OFF; yellow flashes
// RUN    | lamps follow controller requests, request checks active
// FAULT  | latched error; red flashes until fault_clr
module traffic_lamp_driver #(
  parameter int PWM_W     = 4,
  parameter int FLASH_DIV = 8,
  parameter int FAULT_CYC = 2,
  parameter int WDOG_CYC  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             red_in,
  input  logic             yellow_in,
  input  logic             green_in,
  input  logic [2:0]       state_in,
  input  logic [PWM_W-1:0] duty,
  input  logic             fault_clr,
  output logic             lamp_red,
  output logic             lamp_yellow,
  output logic             lamp_green,
  output logic             fault,
  output logic [1:0]       mode
);

  localparam int FL_W  = $clog2(FLASH_DIV);
  localparam int ILL_W = $clog2(FAULT_CYC + 1);
  localparam int WD_W  = $clog2(WDOG_CYC + 1);

  localparam logic [FL_W-1:0]  FLASH_LAST = FL_W'(FLASH_DIV - 1);
  localparam logic [ILL_W-1:0] ILL_SAT    = ILL_W'(FAULT_CYC);
  localparam logic [WD_W-1:0]  WD_SAT     = WD_W'(WDOG_CYC);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_FAULT = 2'b10
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [FL_W-1:0]  flash_cnt_q, flash_cnt_d;
  logic             flash_off_q, flash_off_d;
  logic [ILL_W-1:0] ill_cnt_q, ill_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [2:0]       req_prev_q, req_prev_d;
  logic             lamp_red_q, lamp_red_d;
  logic             lamp_yellow_q, lamp_yellow_d;
  logic             lamp_green_q, lamp_green_d;

  logic [2:0]       req;
  logic             req_onehot;
  logic             req_legal;
  logic             req_changed;
  logic [ILL_W-1:0] ill_inc;
  logic [WD_W-1:0]  wd_inc;
  logic             ill_trip;
  logic             wd_trip;
  logic             flash_phase;
  logic             pwm_on;

  // Request vector uses the same bit order as state_in: bit0 red, bit1 yellow, bit2 green.
  assign req         = {green_in, yellow_in, red_in};
  assign req_onehot  = (req == 3'b001) || (req == 3'b010) || (req == 3'b100);
  assign req_legal   = req_onehot && (req == state_in);
  assign req_changed = (req != req_prev_q);
  assign req_prev_d  = req;

  // Both counters saturate at their trip value. A trip fires on the cycle the
  // incremented count would reach that value.
  assign ill_inc  = (ill_cnt_q == ILL_SAT) ? ill_cnt_q : ill_cnt_q + ILL_W'(1);
  assign wd_inc   = (wd_cnt_q == WD_SAT) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
  assign ill_trip = !req_legal && (ill_inc == ILL_SAT);
  assign wd_trip  = !req_changed && (wd_inc == WD_SAT);

  // The phase is stored inverted, so the cleared register means "lit". Reset
  // lands in IDLE, and IDLE starts lit, the same as any other entry into IDLE.
  assign flash_phase = ~flash_off_q;

`ifdef LAMP_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
  // All-ones duty is forced fully on; otherwise the top count would leave one dark slot.
  assign pwm_on    = (&duty) | (pwm_cnt_q < duty);

  // Free-running PWM ramp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  logic duty_unused;

  assign duty_unused = ^duty;
  assign pwm_on      = 1'b1;
`endif

  // Next-mode decision. Dropping en in RUN wins over a same-cycle fault trip.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_IDLE: begin
        if (en && (state_in != 3'b000)) begin
          mode_d = MODE_RUN;
        end
      end
      MODE_RUN: begin
        if (!en) begin
          mode_d = MODE_IDLE;
        end else if (ill_trip || wd_trip) begin
          mode_d = MODE_FAULT;
        end
      end
      MODE_FAULT: begin
        if (fault_clr) begin
          mode_d = MODE_IDLE;
        end
      end
      default: mode_d = MODE_IDLE;
    endcase
  end

  // Illegal-run and watchdog counters. They count only while RUN continues and
  // are cleared otherwise.
  always_comb begin
    ill_cnt_d = '0;
    wd_cnt_d  = '0;
    if ((mode_q == MODE_RUN) && (mode_d == MODE_RUN)) begin
      ill_cnt_d = req_legal ? '0 : ill_inc;
      wd_cnt_d  = req_changed ? '0 : wd_inc;
    end
  end

  // Flash divider. It restarts lit on every entry into IDLE or FAULT.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    flash_off_d = flash_off_q;
    if ((mode_d != mode_q) && (mode_d != MODE_RUN)) begin
      flash_cnt_d = '0;
      flash_off_d = 1'b0;
    end else if (flash_cnt_q == FLASH_LAST) begin
      flash_cnt_d = '0;
      flash_off_d = ~flash_off_q;
    end else begin
      flash_cnt_d = flash_cnt_q + FL_W'(1);
    end
  end

  // Lamp drive for the next cycle, selected by the current mode.
  always_comb begin
    lamp_red_d    = 1'b0;
    lamp_yellow_d = 1'b0;
    lamp_green_d  = 1'b0;
    case (mode_q)
      MODE_RUN: begin
        lamp_red_d    = red_in & pwm_on;
        lamp_yellow_d = yellow_in & pwm_on;
        lamp_green_d  = green_in & pwm_on;
      end
      MODE_IDLE:  lamp_yellow_d = flash_phase & pwm_on;
      MODE_FAULT: lamp_red_d    = flash_phase & pwm_on;
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q        <= MODE_IDLE;
      flash_cnt_q   <= '0;
      flash_off_q   <= 1'b0;
      ill_cnt_q     <= '0;
      wd_cnt_q      <= '0;
      req_prev_q    <= '0;
      lamp_red_q    <= 1'b0;
      lamp_yellow_q <= 1'b0;
      lamp_green_q  <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_off_q   <= flash_off_d;
      ill_cnt_q     <= ill_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      req_prev_q    <= req_prev_d;
      lamp_red_q    <= lamp_red_d;
      lamp_yellow_q <= lamp_yellow_d;
      lamp_green_q  <= lamp_green_d;
    end
  end

  assign lamp_red    = lamp_red_q;
  assign lamp_yellow = lamp_yellow_q;
  assign lamp_green  = lamp_green_q;
  assign mode        = mode_q;
  assign fault       = (mode_q == MODE_FAULT);

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Bench for traffic_lamp_driver: directed scenarios with literal expectations,
// plus a cycle model of the lamp rules that is compared every cycle.
module tb_traffic_lamp_driver;

  localparam int PWM_W     = 4;
  localparam int FLASH_DIV = 8;
  localparam int FAULT_CYC = 2;
  localparam int WDOG_CYC  = 32;

`ifdef LAMP_PWM_EN
  localparam int EXP_D4 = 4;
  localparam int EXP_D0 = 0;
`else
  localparam int EXP_D4 = 16;
  localparam int EXP_D0 = 16;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             red_in, yellow_in, green_in;
  logic [2:0]       state_in;
  logic [PWM_W-1:0] duty;
  logic             fault_clr;
  logic             lamp_red, lamp_yellow, lamp_green, fault;
  logic [1:0]       mode;

  int n_cmp = 0;
  int n_bad = 0;
  logic started = 1'b0;

  logic [2:0] seq_st [3] = '{3'b001, 3'b010, 3'b100};
  int         seq_len [3] = '{8, 6, 8};

  traffic_lamp_driver #(
    .PWM_W(PWM_W), .FLASH_DIV(FLASH_DIV), .FAULT_CYC(FAULT_CYC), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .red_in(red_in), .yellow_in(yellow_in), .green_in(green_in),
    .state_in(state_in), .duty(duty), .fault_clr(fault_clr),
    .lamp_red(lamp_red), .lamp_yellow(lamp_yellow), .lamp_green(lamp_green),
    .fault(fault), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_st(input logic [2:0] s);
    state_in  = s;
    red_in    = s[0];
    yellow_in = s[1];
    green_in  = s[2];
  endtask

  // Model of the rules. mode: 0 idle, 1 run, 2 fault. flash_t counts the cycles
  // since the last entry into idle or fault; tick counts the cycles since reset.
  typedef struct packed {
    int         mode;
    int         ill;
    int         wd;
    int         flash_t;
    int         tick;
    logic [2:0] prev;
    logic       r;
    logic       y;
    logic       g;
  } mstate_t;

  mstate_t ms;

  function automatic mstate_t model_next(input mstate_t s, input logic e,
                                         input logic [2:0] req, input logic [2:0] st,
                                         input logic [PWM_W-1:0] d, input logic clr);
    mstate_t n;
    logic on, ph, legal;
    int ill_n, wd_n;
    n = s;
`ifdef LAMP_PWM_EN
    on = (d == '1) || ((s.tick % (1 << PWM_W)) < int'(d));
`else
    on = 1'b1;
`endif
    ph = ((s.flash_t / FLASH_DIV) % 2) == 0;
    n.r = 1'b0; n.y = 1'b0; n.g = 1'b0;
    if (s.mode == 1) begin
      n.r = req[0] & on; n.y = req[1] & on; n.g = req[2] & on;
    end else if (s.mode == 2) begin
      n.r = ph & on;
    end else begin
      n.y = ph & on;
    end
    legal = (req == st) && (req inside {3'b001, 3'b010, 3'b100});
    ill_n = 0;
    wd_n  = 0;
    if (s.mode == 0) begin
      if (e && st != 3'b000) n.mode = 1;
    end else if (s.mode == 1) begin
      if (!e) n.mode = 0;
      else begin
        ill_n = legal ? 0 : s.ill + 1;
        wd_n  = (req != s.prev) ? 0 : s.wd + 1;
        if (ill_n >= FAULT_CYC || wd_n >= WDOG_CYC) n.mode = 2;
      end
    end else begin
      if (clr) n.mode = 0;
    end
    n.ill     = (s.mode == 1 && n.mode == 1) ? ill_n : 0;
    n.wd      = (s.mode == 1 && n.mode == 1) ? wd_n : 0;
    n.flash_t = (n.mode != s.mode && n.mode != 1) ? 0 : s.flash_t + 1;
    n.tick    = s.tick + 1;
    n.prev    = req;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ms <= '0;
    else ms <= model_next(ms, en, {green_in, yellow_in, red_in}, state_in, duty, fault_clr);
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && started)
        chk("cycle", 32'({lamp_red, lamp_yellow, lamp_green, fault, mode}),
            32'({ms.r, ms.y, ms.g, (ms.mode == 2), 2'(ms.mode)}));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset_n = 1'b0; en = 1'b0; fault_clr = 1'b0; duty = '1;
    set_st(3'b000);
    #12;
    chk("rst_outputs", 32'({lamp_red, lamp_yellow, lamp_green, fault, mode}), 32'(0));
    #10;
    reset_n = 1'b1;
    started = 1'b1;

    // Disabled after reset: yellow flashes with an 8-cycle half period, starting lit.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("t1_yellow", 32'(lamp_yellow), 32'(((k - 1) / 8) % 2 == 0));
      chk("t1_red_green_mode", 32'({lamp_red, lamp_green, mode}), 32'(0));
    end
    chk("model_t1_idle", 32'(ms.mode), 32'(0));

    // Normal sequence RED/YELLOW/GREEN: each lamp follows its request one cycle later.
    en = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int ph = 0; ph < 3; ph++) begin
        set_st(seq_st[ph]);
        for (int j = 0; j < seq_len[ph]; j++) begin
          @(negedge clk);
          if (rep != 0 || ph != 0 || j != 0) begin
            chk("t2_lamps", 32'({lamp_green, lamp_yellow, lamp_red}), 32'(seq_st[ph]));
            chk("t2_mode", 32'({fault, mode}), 32'(1));
          end
        end
      end
    end

    // Red and green together for two cycles: fault latches and holds until fault_clr.
    red_in = 1'b1; green_in = 1'b1; yellow_in = 1'b0; state_in = 3'b100;
    @(negedge clk);
    chk("t3_ill_1", 32'({fault, mode}), 32'(1));
    @(negedge clk);
    chk("t3_ill_2", 32'({fault, mode}), 32'({1'b1, 2'b10}));
    chk("model_t3_fault", 32'(ms.mode), 32'(2));
    en = 1'b0;
    set_st(3'b000);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("t3_red_flash", 32'(lamp_red), 32'(((i / 8) % 2) == 0));
      chk("t3_hold", 32'({lamp_yellow, lamp_green, fault, mode}), 32'({1'b0, 1'b0, 1'b1, 2'b10}));
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("t3_cleared", 32'({fault, mode}), 32'(0));

    // Watchdog: red held for 32 run cycles trips the watchdog.
    en = 1'b1;
    set_st(3'b001);
    @(negedge clk);
    chk("t4_enter_run", 32'(mode), 32'(1));
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      chk("t4_run", 32'(mode), 32'(1));
    end
    @(negedge clk);
    chk("t4_wdog_trip", 32'({fault, mode}), 32'({1'b1, 2'b10}));
    chk("model_t4_wdog", 32'(ms.mode), 32'(2));
    en = 1'b0; fault_clr = 1'b1;
    set_st(3'b000);
    @(negedge clk);
    fault_clr = 1'b0;
    chk("t4_cleared", 32'(mode), 32'(0));

    // Red held for 31 run cycles, then a change to yellow: no fault.
    en = 1'b1;
    set_st(3'b001);
    @(negedge clk);
    for (int k = 0; k < 31; k++) @(negedge clk);
    set_st(3'b010);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_no_trip", 32'({fault, mode}), 32'(1));
    end
    en = 1'b0;
    set_st(3'b000);
    @(negedge clk);
    chk("t4_idle", 32'(mode), 32'(0));

    // PWM: duty 4 lights 4 of 16 cycles and duty 0 stays dark (fully on without PWM).
    duty = 4'd4; en = 1'b1;
    set_st(3'b001);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cnt += int'(lamp_red);
    end
    chk("t5_duty4", 32'(cnt), 32'(EXP_D4));
    set_st(3'b010);
    duty = 4'd0;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cnt += int'(lamp_yellow);
    end
    chk("t5_duty0", 32'(cnt), 32'(EXP_D0));
    set_st(3'b100);
    duty = '1;
    @(negedge clk);
    chk("t5_full", 32'(lamp_green), 32'(1));
    en = 1'b0;
    set_st(3'b000);
    @(negedge clk);

    // en dropped on the same cycle the second illegal cycle arrives: goes to IDLE, no fault.
    en = 1'b1;
    set_st(3'b100);
    @(negedge clk);
    @(negedge clk);
    red_in = 1'b1;
    @(negedge clk);
    chk("t6_ill_first", 32'({fault, mode}), 32'(1));
    en = 1'b0;
    @(negedge clk);
    chk("t6_en_priority", 32'({fault, mode}), 32'(0));
    set_st(3'b000);

    // An asynchronous reset in the middle of RUN clears the outputs without a clock edge.
    en = 1'b1;
    set_st(3'b001);
    repeat (3) @(negedge clk);
    chk("t6_pre_rst", 32'({lamp_red, mode}), 32'({1'b1, 2'b01}));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_rst", 32'({lamp_red, lamp_yellow, lamp_green, fault, mode}), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b0;
    set_st(3'b000);
    @(negedge clk);
    chk("t6_post_rst_yellow", 32'({lamp_yellow, mode}), 32'({1'b1, 2'b00}));
    repeat (20) @(negedge clk);
    chk("model_t6_idle", 32'(ms.mode), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
